// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// The package holds the FSM state encoding used by the top level.
`timescale 1ns/1ps
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/subtractor1.sv
// Combinational 1-bit full subtractor.
// It computes one difference bit and the borrow passed to the next bit.
`timescale 1ns/1ps
module subtractor1 (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: a - b - bin, LSB first, one bit per clock.
// Uses valid/ready handshakes on both the operand side and the result side.
`timescale 1ns/1ps
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] diff,
   output logic         bout,
   output logic         zero,
   output logic         overflow
);

   localparam int CW = $clog2(N) + 1;

   state_t          r_state;
   logic [N-1:0]    r_shA;
   logic [N-1:0]    r_shB;
   logic [N-1:0]    r_diff;
   logic            r_br;
   logic            r_aMsb;
   logic            r_bMsb;
   logic [CW-1:0]   r_cnt;
   logic            r_bout;
   logic            r_zero;
   logic            r_overflow;

   logic            w_d;
   logic            w_bout;
   logic [N-1:0]    w_diffNext;

   subtractor1 u_sub1 (
      .a    (r_shA[0]),
      .b    (r_shB[0]),
      .bin  (r_br),
      .d    (w_d),
      .bout (w_bout)
   );

   // New bits enter at the MSB so bit i ends up at diff[i] after N shifts.
   assign w_diffNext = {w_d, r_diff[N-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shA      <= '0;
         r_shB      <= '0;
         r_diff     <= '0;
         r_br       <= 1'b0;
         r_aMsb     <= 1'b0;
         r_bMsb     <= 1'b0;
         r_cnt      <= '0;
         r_bout     <= 1'b0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_valid) begin
                  r_shA   <= a;
                  r_shB   <= b;
                  r_br    <= bin;
                  r_aMsb  <= a[N-1];
                  r_bMsb  <= b[N-1];
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_shA  <= r_shA >> 1;
               r_shB  <= r_shB >> 1;
               r_br   <= w_bout;
               r_diff <= w_diffNext;
               r_cnt  <= r_cnt + 1'b1;
               // Flags are captured from the final shift so DONE sees stable values.
               if (r_cnt == CW'(N - 1)) begin
                  r_state    <= DONE;
                  r_bout     <= w_bout;
                  r_zero     <= (w_diffNext == '0);
                  r_overflow <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
               end
            end
            DONE: begin
               if (o_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign i_ready  = (r_state == IDLE);
   assign o_valid  = (r_state == DONE);
   assign diff     = r_diff;
   assign bout     = r_bout;
   assign zero     = r_zero;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with directed and random operands.
// Results are compared against an arithmetic model of a - b - bin.
`timescale 1ns/1ps
module tb_serial_subtractor;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid;
   logic         i_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         o_valid;
   logic         o_ready;
   logic [N-1:0] diff;
   logic         bout;
   logic         zero;
   logic         overflow;

   int checkCount = 0;
   int passCount  = 0;
   int edgeCount  = 0;
   int lastAccept = 0;
   int lastStall  = 0;
   bit haveLast   = 1'b0;

   serial_subtractor #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .diff     (diff),
      .bout     (bout),
      .zero     (zero),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
   endtask

   // Plain integer arithmetic: the true difference tells us both result and borrow.
   task automatic computeModel(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                               output logic [7:0] eDiff, output logic eBout,
                               output logic eZero, output logic eOvf);
      int full;
      full  = int'(ma) - int'(mb) - int'(mbin);
      eDiff = 8'(full & 255);
      eBout = (full < 0);
      eZero = (eDiff == 8'd0);
      eOvf  = (ma[7] != mb[7]) && (eDiff[7] != ma[7]);
   endtask

   // One full operation: accept, wait for the result, optionally stall, then release.
   task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                                input int stall);
      logic [7:0] eDiff;
      logic       eBout, eZero, eOvf;
      int         waitCycles;
      int         accEdge;
      computeModel(ta, tb, tbin, eDiff, eBout, eZero, eOvf);
      i_valid = 1'b1;
      a       = ta;
      b       = tb;
      bin     = tbin;
      o_ready = (stall == 0);
      waitCycles = 0;
      while (!i_ready && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("iReadyBeforeAccept", i_ready, 1);
      @(posedge clk);
      @(negedge clk);
      accEdge = edgeCount;
      if (haveLast) checkOutput("acceptGap", accEdge - lastAccept, 10 + lastStall);
      lastAccept = accEdge;
      lastStall  = stall;
      haveLast   = 1'b1;
      i_valid = 1'b0;
      a       = 8'($urandom);
      b       = 8'($urandom);
      bin     = 1'($urandom);
      waitCycles = 0;
      while (!o_valid && waitCycles < 40) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("latency", waitCycles, N);
      checkOutput("diff", diff, eDiff);
      checkOutput("bout", bout, eBout);
      checkOutput("zero", zero, eZero);
      checkOutput("overflow", overflow, eOvf);
      for (int s = 0; s < stall; s++) begin
         i_valid = 1'b1;
         a       = 8'($urandom);
         b       = 8'($urandom);
         @(negedge clk);
         checkOutput("stallValid", o_valid, 1);
         checkOutput("stallReady", i_ready, 0);
         checkOutput("stallDiff", diff, eDiff);
         checkOutput("stallFlags", {bout, zero, overflow}, {eBout, eZero, eOvf});
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(negedge clk);
      checkOutput("releaseValid", o_valid, 0);
      checkOutput("releaseReady", i_ready, 1);
   endtask

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int validSeen;
      rst     = 1'b1;
      i_valid = 1'b1;
      o_ready = 1'b1;
      a       = 8'h55;
      b       = 8'h11;
      bin     = 1'b0;
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      i_valid = 1'b0;
      @(negedge clk);
      checkOutput("resetReady", i_ready, 1);
      checkOutput("resetValid", o_valid, 0);
      checkOutput("resetDiff", diff, 0);
      checkOutput("resetFlags", {bout, zero, overflow}, 3'b000);

      applyStimulus(8'h05, 8'h03, 1'b0, 0);
      applyStimulus(8'h03, 8'h05, 1'b0, 0);
      applyStimulus(8'h80, 8'h01, 1'b0, 0);
      applyStimulus(8'h10, 8'h0F, 1'b1, 0);
      applyStimulus(8'h00, 8'hFF, 1'b1, 0);
      applyStimulus(8'h5A, 8'h21, 1'b0, 5);
      applyStimulus(8'h01, 8'h01, 1'b0, 0);

      // Abort an operation three bits in; no result may appear afterwards.
      i_valid = 1'b1;
      a       = 8'h3C;
      b       = 8'h11;
      bin     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abortReady", i_ready, 1);
      checkOutput("abortValid", o_valid, 0);
      checkOutput("abortDiff", diff, 0);
      validSeen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (o_valid) validSeen++;
      end
      checkOutput("abortNoPulse", validSeen, 0);
      haveLast = 1'b0;
      applyStimulus(8'h7F, 8'h80, 1'b0, 0);

      for (int n = 0; n < 1000; n++) begin
         applyStimulus(8'($urandom), 8'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing a − b − bin one bit per clock, LSB first, with a single registered borrow flip-flop. It is the inverse-direction counterpart to the team's ripple-carry adder chain. It trades the combinational ripple for an N-cycle sequential datapath behind valid/ready handshakes on both input and output. Intended as the arithmetic core for area-constrained datapaths and as a reference for comparing against the ripple adders.

## Interface
- N, default 8: operand/result width, ≥ 2.
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operands a, b, bin are valid this cycle.
- i_ready  output  1  block can accept operands; high only in IDLE.
- a  input  N  minuend, unsigned or two's complement.
- b  input  N  subtrahend.
- bin  input  1  borrow-in.
- o_valid  output  1  result fields are valid; high only in DONE.
- o_ready  input  1  consumer accepts the result.
- diff  output  N  a − b − bin mod 2^N.
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
- zero  output  1  diff == 0.
- overflow  output  1  signed overflow of the two's-complement subtraction.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - i_ready = 1.
  - On i_valid, latch a into shift register A, b into shift register B, and bin into the borrow flop.
  - Latch a[N-1] and b[N-1] for the overflow computation.
  - Clear the bit counter and go to RUN.
- RUN: each cycle, one 1-bit full subtract of A[0], B[0], and borrow.
  - d = A[0] ^ B[0] ^ br.
  - br_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br).
  - Shift d into the diff register MSB-side (right shift), so that bit i lands at diff[i] after N shifts.
  - Shift A and B right and increment the counter.
  - After the N-th shift, go to DONE.
- DONE:
  - o_valid = 1; diff, bout, zero, and overflow are held stable.
  - bout = final borrow. zero = (diff == 0). overflow = (a_msb != b_msb) && (diff[N-1] != a_msb).
  - On o_ready, go to IDLE.
- i_valid is ignored outside IDLE. Operands are not required to stay stable after acceptance.
- Counter width is $clog2(N)+1 and saturates logically at N; it never wraps within an operation.

## Timing
- Reset:
  - State goes to IDLE. diff = 0, bout = 0, zero = 0, overflow = 0, o_valid = 0. Borrow flop, counter, and shift registers are cleared.
  - i_ready = 1 from the first cycle after rst deasserts. While rst is high, i_valid and o_ready are ignored.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded, with no o_valid pulse, and the block is in IDLE the next cycle.
- Latency:
  - Acceptance at edge 0.
  - Bits are processed at edges 1..N.
  - o_valid is high in the cycle following edge N.
- Output handshake completes at the first edge where o_valid && o_ready. The earliest completion is edge N+1.
- i_ready rises the cycle after the output handshake, so the next acceptance is at edge N+2 at the earliest. Throughput is one operation per N+2 cycles.
- Backpressure: o_ready low holds DONE indefinitely with all outputs unchanged.
- Outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Structure
- Package serial_sub_pkg holds the state enum (IDLE, RUN, DONE) as a typedef.
- Sub-module subtractor1, a combinational 1-bit full subtractor (a, b, bin → d, bout), is instantiated once in the RUN datapath.
- The top level holds the FSM, counter, shift registers, borrow flop, and flag logic.

## Test plan
All cases use N = 8.
- a=0x05, b=0x03, bin=0, o_ready=1 → o_valid exactly 8 cycles after accept; diff=0x02, bout=0, zero=0, overflow=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, bout=0, overflow=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, zero=1, bout=0. Also a=0x00, b=0xFF, bin=1 → diff=0x00, bout=1, zero=1.
- Hold o_ready=0 for 5 cycles in DONE, with i_valid=1 and changing a and b → outputs unchanged, i_ready=0, no new accept. Then o_ready=1 → IDLE next cycle, and the next accept lands at edge N+2 relative to the prior accept at minimum.
- Assert rst for one cycle after 3 RUN cycles → next cycle IDLE, i_ready=1, o_valid never pulses. A fresh a=0x7F, b=0x80 then gives diff=0xFF, bout=1, overflow=1.
- Random operands (≥1000) with random o_ready stalls → every result matches a golden model: (a − b − bin) mod 256, borrow, zero, and signed overflow.
